// File: rtl/debounce_pkg.sv
// -----------------------------------------------------------------------------
// debounce_pkg
// Shared types and default parameter values for the push-button debouncer.
//   debounce_state_t : stability-timer FSM states
//   DEFAULT_*        : default parameter values used by button_debouncer
// -----------------------------------------------------------------------------
package debounce_pkg;

    typedef enum logic [1:0] {
        RELEASED     = 2'd0,
        WAIT_PRESS   = 2'd1,
        PRESSED      = 2'd2,
        WAIT_RELEASE = 2'd3
    } debounce_state_t;

    // 2 flops is the minimum for metastability settling on an async pin.
    localparam int unsigned DEFAULT_SYNC_STAGES       = 2;
    // 10 ms at 100 MHz.
    localparam int unsigned DEFAULT_DEBOUNCE_CYCLES   = 1_000_000;
    // 1 s at 100 MHz.
    localparam int unsigned DEFAULT_LONG_PRESS_CYCLES = 100_000_000;

endpackage : debounce_pkg

// File: rtl/bit_synchronizer.sv
// -----------------------------------------------------------------------------
// bit_synchronizer
// Multi-flop synchronizer bringing one asynchronous bit into the clk domain.
// Reusable for any slow switch/button input.
// Parameters:
//   STAGES : number of flops in the chain (>= 2)
// Ports:
//   clk   : clock, all flops on posedge
//   reset : synchronous active-high reset, clears the whole chain
//   d     : asynchronous input bit
//   q     : synchronized output (last stage of the chain)
// -----------------------------------------------------------------------------
module bit_synchronizer #(
    parameter int unsigned STAGES = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] sync_q;

    // NOTE: sequential state uses non-blocking (<=) so every flop samples the
    // pre-edge value of its neighbour; blocking here would collapse the chain.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[STAGES-2:0], d};
        end
    end

    assign q = sync_q[STAGES-1];

endmodule : bit_synchronizer

// File: rtl/button_debouncer.sv
// -----------------------------------------------------------------------------
// button_debouncer
// Conditions a raw mechanical push-button: synchronizes the pin, rejects
// bounce with a stability-timer FSM and produces a clean level plus one-cycle
// press/release strobes. All outputs are registered.
//
// Optional feature (compile-time macro LONG_PRESS_EN):
//   defined   : long_press_pulse strobes once per accepted press after the
//               button has been held LONG_PRESS_CYCLES cycles in PRESSED.
//   undefined : no long-press counter is built; long_press_pulse is tied 0.
//
// Parameters:
//   SYNC_STAGES       : synchronizer depth (>= 2)
//   DEBOUNCE_CYCLES   : consecutive stable samples to accept a change (>= 2)
//   LONG_PRESS_CYCLES : hold time before long_press_pulse (LONG_PRESS_EN only)
// Ports:
//   clk              : system clock, posedge
//   reset            : synchronous active-high reset
//   button           : raw asynchronous button pin, active-high
//   button_clean     : debounced level
//   press_pulse      : one-cycle strobe on accepted press
//   release_pulse    : one-cycle strobe on accepted release
//   long_press_pulse : one-cycle strobe on long hold
// -----------------------------------------------------------------------------
module button_debouncer
    import debounce_pkg::*;
#(
    parameter int unsigned SYNC_STAGES       = DEFAULT_SYNC_STAGES,
    parameter int unsigned DEBOUNCE_CYCLES   = DEFAULT_DEBOUNCE_CYCLES,
    parameter int unsigned LONG_PRESS_CYCLES = DEFAULT_LONG_PRESS_CYCLES
) (
    input  logic clk,
    input  logic reset,
    input  logic button,
    output logic button_clean,
    output logic press_pulse,
    output logic release_pulse,
    output logic long_press_pulse
);

    // ------------------------------------------------------------------
    // Elaboration-time parameter legality
    // ------------------------------------------------------------------
    if (SYNC_STAGES < 2) begin : g_bad_sync_stages
        $error("button_debouncer: SYNC_STAGES must be >= 2");
    end
    if (DEBOUNCE_CYCLES < 2) begin : g_bad_debounce_cycles
        $error("button_debouncer: DEBOUNCE_CYCLES must be >= 2");
    end
    if (LONG_PRESS_CYCLES < 2) begin : g_bad_long_press_cycles
        $error("button_debouncer: LONG_PRESS_CYCLES must be >= 2");
    end

    localparam int unsigned TW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [TW-1:0] TIMER_LAST = TW'(DEBOUNCE_CYCLES - 1);
    localparam logic [TW-1:0] TIMER_MAX  = TW'(DEBOUNCE_CYCLES);

    // ------------------------------------------------------------------
    // Synchronizer: the only reader of the raw pin
    // ------------------------------------------------------------------
    logic btn_sync;

    bit_synchronizer #(
        .STAGES (SYNC_STAGES)
    ) u_sync (
        .clk   (clk),
        .reset (reset),
        .d     (button),
        .q     (btn_sync)
    );

    // ------------------------------------------------------------------
    // FSM process 1: state, timer and registered outputs
    // ------------------------------------------------------------------
    debounce_state_t state_q, state_d;
    logic [TW-1:0]   timer_q, timer_d;
    logic            button_clean_q, button_clean_d;
    logic            press_pulse_q, press_pulse_d;
    logic            release_pulse_q, release_pulse_d;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q         <= RELEASED;
            timer_q         <= '0;
            button_clean_q  <= 1'b0;
            press_pulse_q   <= 1'b0;
            release_pulse_q <= 1'b0;
        end else begin
            state_q         <= state_d;
            timer_q         <= timer_d;
            button_clean_q  <= button_clean_d;
            press_pulse_q   <= press_pulse_d;
            release_pulse_q <= release_pulse_d;
        end
    end

    // ------------------------------------------------------------------
    // FSM process 2: next state and stability timer
    // ------------------------------------------------------------------
    // NOTE: every variable assigned in always_comb gets a default first so no
    // path through the case leaves it unassigned (which would infer a latch).
    always_comb begin
        state_d = state_q;
        timer_d = timer_q;
        unique case (state_q)
            RELEASED: begin
                if (btn_sync) begin
                    state_d = WAIT_PRESS;
                    timer_d = TW'(1);
                end
            end
            WAIT_PRESS: begin
                if (!btn_sync) begin
                    // Glitch: back to idle, full window restarts next time.
                    state_d = RELEASED;
                    timer_d = '0;
                end else if (timer_q == TIMER_LAST) begin
                    state_d = PRESSED;
                    timer_d = '0;
                end else if (timer_q != TIMER_MAX) begin
                    timer_d = timer_q + TW'(1);
                end
            end
            PRESSED: begin
                if (!btn_sync) begin
                    state_d = WAIT_RELEASE;
                    timer_d = TW'(1);
                end
            end
            WAIT_RELEASE: begin
                if (btn_sync) begin
                    // Release bounce: stay pressed, no strobe.
                    state_d = PRESSED;
                    timer_d = '0;
                end else if (timer_q == TIMER_LAST) begin
                    state_d = RELEASED;
                    timer_d = '0;
                end else if (timer_q != TIMER_MAX) begin
                    timer_d = timer_q + TW'(1);
                end
            end
            default: begin
                state_d = RELEASED;
                timer_d = '0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // FSM process 3: outputs, decoded from the accepted transitions so the
    // strobes and the level change land on the same edge.
    // ------------------------------------------------------------------
    always_comb begin
        press_pulse_d   = (state_q == WAIT_PRESS)   && (state_d == PRESSED);
        release_pulse_d = (state_q == WAIT_RELEASE) && (state_d == RELEASED);
        button_clean_d  = button_clean_q;
        if (press_pulse_d) begin
            button_clean_d = 1'b1;
        end else if (release_pulse_d) begin
            button_clean_d = 1'b0;
        end
    end

    assign button_clean  = button_clean_q;
    assign press_pulse   = press_pulse_q;
    assign release_pulse = release_pulse_q;

    // ------------------------------------------------------------------
    // Long-press detector
    // ------------------------------------------------------------------
`ifdef LONG_PRESS_EN
    localparam int unsigned LW = $clog2(LONG_PRESS_CYCLES + 1);
    localparam logic [LW-1:0] LONG_LAST = LW'(LONG_PRESS_CYCLES - 1);
    localparam logic [LW-1:0] LONG_MAX  = LW'(LONG_PRESS_CYCLES);

    logic [LW-1:0] long_cnt_q, long_cnt_d;
    logic          long_pulse_q, long_pulse_d;

    // Cleared only on a fresh accepted press, so a release bounce that returns
    // to PRESSED keeps the accumulated hold time. Saturating one past the
    // firing value guarantees a single strobe per press.
    always_comb begin
        long_cnt_d   = long_cnt_q;
        long_pulse_d = 1'b0;
        if (press_pulse_d) begin
            long_cnt_d = '0;
        end else if ((state_q == PRESSED) && (long_cnt_q != LONG_MAX)) begin
            long_cnt_d   = long_cnt_q + LW'(1);
            long_pulse_d = (long_cnt_q == LONG_LAST);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            long_cnt_q   <= '0;
            long_pulse_q <= 1'b0;
        end else begin
            long_cnt_q   <= long_cnt_d;
            long_pulse_q <= long_pulse_d;
        end
    end

    assign long_press_pulse = long_pulse_q;
`else
    assign long_press_pulse = 1'b0;
`endif

endmodule : button_debouncer
